// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial transmitter.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit-counter width for a word of the given size; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable up-counter that saturates at MAX_COUNT and flags the terminal count.
module bit_counter
    import serializer_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 7,
    parameter int unsigned CW        = cnt_width(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tc = (count_q == CW'(MAX_COUNT));

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial transmitter: valid/ready word intake, one bit per clock out,
// with back-to-back words when a new word arrives during the last-bit cycle.
module p2s_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             serial_o,
    output logic             serial_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int unsigned CW = cnt_width(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("p2s_serializer: WIDTH must be in 2..32");
        end
    endgenerate

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic             tc;
    logic             accept;
    logic             out_bit;

    assign accept  = valid_i && ready_o;
    assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A handshake in the last-bit cycle keeps us in SHIFT with no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)       state_d = SHIFT;
            SHIFT:   if (tc && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o        = 1'b0;
        busy_o         = 1'b0;
        serial_valid_o = 1'b0;
        last_o         = 1'b0;
        serial_o       = 1'b0;
        if (state_q == IDLE) begin
            ready_o = 1'b1;
        end else begin
            ready_o        = tc;
            busy_o         = 1'b1;
            serial_valid_o = 1'b1;
            last_o         = tc;
            serial_o       = out_bit;
        end
    end

    // Zeros are shifted in, so the register drains to 0 after the last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else if (accept) begin
            shreg_q <= data_i;
        end else if (state_q == SHIFT) begin
            if (MSB_FIRST) begin
                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    bit_counter #(
        .MAX_COUNT (WIDTH - 1),
        .CW        (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept || (state_q == SHIFT && tc)),
        .en    (state_q == SHIFT),
        .tc    (tc)
    );

endmodule
